// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper for a 3-input combinational gate.
//
// After a start request the block drives {in1,in2,in3} through rows 000..111 in
// ascending order. Each row is held for SETTLE_CYCLES clocks. On the last cycle of
// each row the gate output is sampled into observed[7-row]. Once row 7 has been
// captured, the block compares the captured table against TT and pulses done.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_i      single-cycle sweep request; ignored while busy or in the done cycle
//   dut_out_i    output of the gate under test (combinational in in1..in3)
//   in1_o        gate input, row index bit 2
//   in2_o        gate input, row index bit 1
//   in3_o        gate input, row index bit 0
//   busy_o       high while a sweep is in progress
//   done_o       one-cycle pulse when a sweep completes
//   pass_o       observed == TT; valid from done until the next accepted start
//   observed_o   captured table, MSB-first (row i in bit 7-i)
//   fail_mask_o  observed ^ TT; a set bit marks a mismatching row
module truth_table_sweeper #(
  parameter logic [7:0]  TT            = 8'hCD,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       dut_out_i,
  output logic       in1_o,
  output logic       in2_o,
  output logic       in3_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [7:0] observed_o,
  output logic [7:0] fail_mask_o
);

  // Parameter sanity checks at elaboration time.
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("truth_table_sweeper: SETTLE_CYCLES must be at least 1");
  end

  if (CNT_W == 0 || (CNT_W < 32 && (32'd1 << CNT_W) <= SETTLE_CYCLES)) begin : g_bad_cnt_w
    $error("truth_table_sweeper: CNT_W too narrow for SETTLE_CYCLES");
  end

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       in_q, in_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [7:0]       obs_q, obs_d;
  logic [7:0]       mask_q, mask_d;

  // Table as it would look after capturing the current row this cycle.
  logic [7:0] obs_cap;

  always_comb begin
    obs_cap = obs_q;
    obs_cap[3'd7 - row_q] = dut_out_i;
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    in_d    = in_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    obs_d   = obs_q;
    mask_d  = mask_q;

    unique case (state_q)
      StIdle: begin
        in_d   = 3'b000;
        busy_d = 1'b0;
        if (start_i) begin
          state_d = StRun;
          busy_d  = 1'b1;
          row_d   = 3'd0;
          cnt_d   = '0;
          in_d    = 3'b000;
          obs_d   = 8'h00;
          mask_d  = 8'h00;
          pass_d  = 1'b0;
        end
      end

      StRun: begin
        busy_d = 1'b1;
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          obs_d = obs_cap;
          if (row_q == 3'd7) begin
            // Final row: results include the row-7 sample taken on this edge.
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            in_d    = 3'b000;
            mask_d  = obs_cap ^ TT;
            pass_d  = (obs_cap == TT);
          end else begin
            row_d = row_q + 3'd1;
            in_d  = row_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StDone: begin
        in_d    = 3'b000;
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        in_d    = 3'b000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      row_q   <= 3'd0;
      cnt_q   <= '0;
      in_q    <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      obs_q   <= 8'h00;
      mask_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      obs_q   <= obs_d;
      mask_q  <= mask_d;
    end
  end

  assign in1_o       = in_q[2];
  assign in2_o       = in_q[1];
  assign in3_o       = in_q[0];
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign observed_o  = obs_q;
  assign fail_mask_o = mask_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (settle 4 and settle 1) share a
// gate model whose truth table is chosen per sweep. Expected results are queued
// when a sweep is launched; per-instance monitors check row sequencing, busy,
// done timing and the final results against the queued expectation.
module tb_truth_table_sweeper;

  localparam logic [7:0]  TtExp = 8'hCD;
  localparam int unsigned S4    = 4;
  localparam int unsigned S1    = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start4, start1;
  logic [7:0] gate_tt;

  logic       in1_4, in2_4, in3_4, busy4, done4, pass4, dut_out4;
  logic [7:0] obs4, mask4;
  logic       in1_1, in2_1, in3_1, busy1, done1, pass1, dut_out1;
  logic [7:0] obs1, mask1;

  // Gate under test: row {a,b,c}=i outputs gate_tt[7-i].
  assign dut_out4 = gate_tt[3'd7 - {in1_4, in2_4, in3_4}];
  assign dut_out1 = gate_tt[3'd7 - {in1_1, in2_1, in3_1}];

  truth_table_sweeper #(
    .TT           (TtExp),
    .SETTLE_CYCLES(S4),
    .CNT_W        (8)
  ) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start4),
    .dut_out_i  (dut_out4),
    .in1_o      (in1_4),
    .in2_o      (in2_4),
    .in3_o      (in3_4),
    .busy_o     (busy4),
    .done_o     (done4),
    .pass_o     (pass4),
    .observed_o (obs4),
    .fail_mask_o(mask4)
  );

  truth_table_sweeper #(
    .TT           (TtExp),
    .SETTLE_CYCLES(S1),
    .CNT_W        (2)
  ) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start1),
    .dut_out_i  (dut_out1),
    .in1_o      (in1_1),
    .in2_o      (in2_1),
    .in3_o      (in3_1),
    .busy_o     (busy1),
    .done_o     (done1),
    .pass_o     (pass1),
    .observed_o (obs1),
    .fail_mask_o(mask1)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  obs;
    logic [7:0]  mask;
    logic        pass;
    int unsigned start_edge;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference: sweeping rows 0..7 reads out the gate's function row by row.
  function automatic exp_t model(input logic [7:0] g, input int unsigned s_edge);
    exp_t e;
    logic a, b, c, y;
    e.obs = 8'h00;
    for (int r = 0; r < 8; r++) begin
      a = ((r >> 2) & 1) != 0;
      b = ((r >> 1) & 1) != 0;
      c = (r & 1) != 0;
      y = g[7 - (4 * int'(a) + 2 * int'(b) + int'(c))];
      e.obs[7-r] = y;
    end
    e.mask       = e.obs ^ TtExp;
    e.pass       = (e.obs == TtExp);
    e.start_edge = s_edge;
    return e;
  endfunction

  exp_t m4, m1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (q4.size() > 0 && cyc >= q4[0].start_edge && cyc < q4[0].start_edge + 8 * S4) begin
        check("dut4 row drive", {29'd0, in1_4, in2_4, in3_4}, (cyc - q4[0].start_edge) / S4);
        check("dut4 busy in sweep", {31'd0, busy4}, 32'd1);
      end else if (q4.size() == 0) begin
        check("dut4 busy when idle", {31'd0, busy4}, 32'd0);
      end
      if (done4) begin
        if (q4.size() == 0) begin
          check("dut4 unexpected done", {31'd0, done4}, 32'd0);
        end else begin
          m4 = q4.pop_front();
          check("dut4 done latency", cyc, m4.start_edge + 8 * S4);
          check("dut4 observed", {24'd0, obs4}, {24'd0, m4.obs});
          check("dut4 fail_mask", {24'd0, mask4}, {24'd0, m4.mask});
          check("dut4 pass", {31'd0, pass4}, {31'd0, m4.pass});
          check("dut4 ins at done", {29'd0, in1_4, in2_4, in3_4}, 32'd0);
          check("dut4 busy at done", {31'd0, busy4}, 32'd0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (q1.size() > 0 && cyc >= q1[0].start_edge && cyc < q1[0].start_edge + 8 * S1) begin
        check("dut1 row drive", {29'd0, in1_1, in2_1, in3_1}, (cyc - q1[0].start_edge) / S1);
        check("dut1 busy in sweep", {31'd0, busy1}, 32'd1);
      end else if (q1.size() == 0) begin
        check("dut1 busy when idle", {31'd0, busy1}, 32'd0);
      end
      if (done1) begin
        if (q1.size() == 0) begin
          check("dut1 unexpected done", {31'd0, done1}, 32'd0);
        end else begin
          m1 = q1.pop_front();
          check("dut1 done latency", cyc, m1.start_edge + 8 * S1);
          check("dut1 observed", {24'd0, obs1}, {24'd0, m1.obs});
          check("dut1 fail_mask", {24'd0, mask1}, {24'd0, m1.mask});
          check("dut1 pass", {31'd0, pass1}, {31'd0, m1.pass});
          check("dut1 ins at done", {29'd0, in1_1, in2_1, in3_1}, 32'd0);
        end
      end
    end
  end

  // Launch one sweep on the selected instance and wait (bounded) for it to finish.
  // extra_at > 0 pulses start again that many cycles after launch.
  task automatic run_sweep(input bit sel1, input logic [7:0] g, input int extra_at,
                           output exp_t e);
    int          waited;
    int unsigned s;
    int unsigned limit;
    @(negedge clk);
    #1;
    gate_tt = g;
    s       = cyc + 1;
    e       = model(g, s);
    limit   = 8 * (sel1 ? S1 : S4) + 20;
    if (sel1) begin
      q1.push_back(e);
      start1 = 1'b1;
    end else begin
      q4.push_back(e);
      start4 = 1'b1;
    end
    waited = 0;
    @(negedge clk);
    #1;
    start1 = 1'b0;
    start4 = 1'b0;
    while ((sel1 ? q1.size() : q4.size()) > 0 && waited < int'(limit)) begin
      @(negedge clk);
      #1;
      waited++;
      if (sel1) start1 = (waited == extra_at);
      else      start4 = (waited == extra_at);
    end
    start1 = 1'b0;
    start4 = 1'b0;
    if ((sel1 ? q1.size() : q4.size()) > 0) begin
      check("sweep timeout", sel1 ? q1.size() : q4.size(), 32'd0);
      q1.delete();
      q4.delete();
    end
  endtask

  task automatic check_held(input exp_t e);
    repeat (3) @(negedge clk);
    #1;
    check("dut4 observed held", {24'd0, obs4}, {24'd0, e.obs});
    check("dut4 pass held", {31'd0, pass4}, {31'd0, e.pass});
    check("dut4 mask held", {24'd0, mask4}, {24'd0, e.mask});
  endtask

  exp_t        e;
  logic [7:0]  rnd;
  int unsigned s_rst;

  initial begin
    rst_n   = 1'b0;
    start4  = 1'b0;
    start1  = 1'b0;
    gate_tt = TtExp;
    #1;
    check("reset dut4 outputs", {16'd0, in1_4, in2_4, in3_4, busy4, done4, pass4, 2'd0, obs4, mask4}
          & 32'h0000_FFFF | {16'd0, 2'd0, 6'd0, 8'd0}, 32'd0);
    check("reset dut1 outputs", {8'd0, in1_1, in2_1, in3_1, busy1, done1, pass1, 2'd0, obs1, mask1},
          32'd0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Ideal gate, stuck-at-1, bit-order probes.
    run_sweep(1'b0, TtExp, 0, e);
    check_held(e);
    run_sweep(1'b0, 8'hFF, 0, e);
    check("stuck1 mask const", {24'd0, mask4}, 32'h32);
    run_sweep(1'b0, 8'h0F, 0, e);
    run_sweep(1'b0, 8'h55, 0, e);

    // Second start while busy must be ignored.
    run_sweep(1'b0, TtExp, 10, e);
    check_held(e);

    for (int i = 0; i < 6; i++) begin
      rnd = 8'($urandom);
      run_sweep(1'b0, rnd, (i % 2 == 0) ? int'($urandom_range(1, 30)) : 0, e);
    end

    // Settle of one cycle.
    run_sweep(1'b1, TtExp, 0, e);
    for (int i = 0; i < 4; i++) begin
      rnd = 8'($urandom);
      run_sweep(1'b1, rnd, 0, e);
    end

    // Asynchronous reset in the middle of a sweep.
    @(negedge clk);
    #1;
    gate_tt = 8'($urandom);
    s_rst   = cyc + 1;
    e       = model(gate_tt, s_rst);
    q4.push_back(e);
    start4 = 1'b1;
    @(negedge clk);
    #1;
    start4 = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset dut4 zero", {8'd0, in1_4, in2_4, in3_4, busy4, done4, pass4, 2'd0, obs4, mask4},
          32'd0);
    check("midreset dut1 zero", {8'd0, in1_1, in2_1, in3_1, busy1, done1, pass1, 2'd0, obs1, mask1},
          32'd0);
    q4.delete();
    q1.delete();
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    run_sweep(1'b0, TtExp, 0, e);
    check_held(e);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
